gray_decoder: RTL
=================

GRAY_DECODER -- requirements
Module: gray_decoder

Interface
REQ-001 SHALL have parameter W, default 4, meaning the pointer width in bits (W >= 1).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port en, input, 1 bit: sample strobe; gray_in is accepted on a clk edge with en=1.
REQ-005 SHALL have port gray_in, input, W bits: Gray-coded pointer, such as a synchronized Gray counter output.
REQ-006 SHALL have port bin_out, output, W bits: binary equivalent of the last accepted sample.
REQ-007 SHALL have port delta, output, W bits: bin_out minus the previous bin_out, modulo 2^W.
REQ-008 SHALL have port valid, output, 1 bit: one-cycle pulse marking new bin_out and delta.
REQ-009 SHALL have port step_err, output, 1 bit: sticky flag for an illegal Gray step.

Function
REQ-010 SHALL register gray_in into stage-1 register gray_q on each clk edge with en=1; gray_q SHALL hold when en=0.
REQ-011 SHALL compute the binary value as b[W-1]=g[W-1] and b[i]=b[i+1]^g[i] for i=W-2..0; for W=1, b=g.
REQ-012 SHALL register the decoded binary value of gray_q into bin_out in stage 2, one cycle after stage 1.
REQ-013 SHALL have a latency of exactly 2 cycles: en at edge N gives valid=1 after edge N+1, and bin_out is valid in that cycle.
REQ-014 SHALL assert valid for exactly one cycle per accepted sample; back-to-back en SHALL give back-to-back valid at a throughput of 1 sample per cycle.
REQ-015 SHALL hold bin_out and delta stable while valid=0.
REQ-016 SHALL compute delta in stage 2 as the new binary value minus the previous bin_out, truncated to W bits; wrap from 2^W-1 to 0 SHALL give delta=1.
REQ-017 SHALL compute delta for the first sample after reset against a previous value of 0.
REQ-018 SHALL count the differing bits between each accepted gray_in and the previously accepted sample (0 after reset).
REQ-019 SHALL treat a Hamming distance of 0 or 1 as legal; a distance of 2 or more SHALL set step_err.
REQ-020 SHALL set step_err in the same cycle in which that sample's valid pulse is asserted.
REQ-021 SHALL keep step_err at 1 until rst.
REQ-022 SHALL still decode and output samples normally after an error.
REQ-023 SHALL, when en=1 and rst=1 on the same edge, give reset priority and discard the sample.

Reset
REQ-024 SHALL clear on rst=1 at a clk edge: gray_q=0, bin_out=0, delta=0, valid=0, step_err=0, and previous-sample state=0.
REQ-025 SHALL, if rst occurs mid-pipeline (en at edge N, rst at edge N+1), produce no valid pulse for that sample.
REQ-026 SHALL hold all outputs at their reset values from the reset edge until the next accepted sample propagates.

Configuration
REQ-027 SHALL, with macro GRAY_DECODER_STEP_CHECK_EN defined, include the Hamming-distance checker and the step_err register (REQ-018 to REQ-022).
REQ-028 SHALL, without GRAY_DECODER_STEP_CHECK_EN, omit the checker logic and tie step_err to constant 0; all other behaviour SHALL be identical.

Verification
REQ-029 SHALL cover, with W=4, en=1 on consecutive cycles and gray_in 0000,0001,0011,0010,0110: bin_out 0,1,2,3,4; delta 0,1,1,1,1; valid high for 5 cycles from 2 cycles after the first en; step_err=0.
REQ-030 SHALL cover wrap, with W=4: gray_in 1000 (bin 15), then 0000 -> bin_out 15 then 0, delta 1, step_err=0.
REQ-031 SHALL cover an illegal step, with W=4 and the macro defined: gray_in 0000 then 0011 -> bin_out 2, step_err=1 with that valid and held through 20 further legal samples until rst.
REQ-032 SHALL cover reset mid-operation: en with gray_in 0101, rst on the next edge -> no valid pulse, bin_out=0, step_err=0.
REQ-033 SHALL cover gaps, with W=1: gray_in 1, idle 3 cycles, then 0 -> bin_out 1 then 0, delta 1 then 1, valid pulses separated by 4 cycles.
REQ-034 SHALL cover macro removal: repeat REQ-031 without GRAY_DECODER_STEP_CHECK_EN -> bin_out and delta identical, step_err=0 throughout.

Source files
------------

// File: rtl/gray_decoder.sv
// Two-stage Gray-to-binary pointer decoder with modulo-2^W delta and a one-cycle valid pulse.
// Optional sticky illegal-step checker enabled by defining GRAY_DECODER_STEP_CHECK_EN.
module gray_decoder #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] gray_in,
  output logic [W-1:0] bin_out,
  output logic [W-1:0] delta,
  output logic         valid,
  output logic         step_err
);

  // MSB-first prefix XOR; a single-bit pointer decodes to itself
  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = g;
    for (int i = int'(W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [W-1:0] gray_q, gray_d;
  logic         v1_q, v1_d;
  logic [W-1:0] bin_q, bin_d;
  logic [W-1:0] delta_q, delta_d;
  logic         valid_q, valid_d;
  logic [W-1:0] bin_new;

  // Stage 1 captures the sample; stage 2 decodes it against the held bin_out
  always_comb begin
    gray_d  = gray_q;
    v1_d    = en;
    bin_d   = bin_q;
    delta_d = delta_q;
    valid_d = 1'b0;
    bin_new = gray2bin(gray_q);
    if (en) begin
      gray_d = gray_in;
    end
    if (v1_q) begin
      bin_d   = bin_new;
      delta_d = bin_new - bin_q;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_q  <= '0;
      v1_q    <= 1'b0;
      bin_q   <= '0;
      delta_q <= '0;
      valid_q <= 1'b0;
    end else begin
      gray_q  <= gray_d;
      v1_q    <= v1_d;
      bin_q   <= bin_d;
      delta_q <= delta_d;
      valid_q <= valid_d;
    end
  end

  assign bin_out = bin_q;
  assign delta   = delta_q;
  assign valid   = valid_q;

`ifdef GRAY_DECODER_STEP_CHECK_EN
  logic [W-1:0] diff;
  logic         err1_q, err1_d;
  logic         step_err_q, step_err_d;

  // gray_q is the previously accepted sample; x & (x-1) is nonzero iff x has 2+ bits set
  always_comb begin
    diff       = gray_in ^ gray_q;
    err1_d     = |(diff & (diff - W'(1)));
    step_err_d = step_err_q | (v1_q & err1_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err1_q     <= 1'b0;
      step_err_q <= 1'b0;
    end else begin
      err1_q     <= err1_d;
      step_err_q <= step_err_d;
    end
  end

  assign step_err = step_err_q;
`else
  assign step_err = 1'b0;
`endif

endmodule
